// File: rtl/subdomain_sched_pkg.sv
// Shared types and sizing helpers for the sub-domain resource schedulers.
package subdomain_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  localparam int DEF_NUM_REQ = 5;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/subdomain_rr_pick.sv
// Rotating priority encoder: first set request strictly after last_ptr,
// wrapping modulo NUM_REQ. Purely combinational so sibling schedulers can
// share it.
module rr_pick
  import subdomain_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // Walk the candidates in rotated order and keep the first hit.
  always_comb begin
    int cand;
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_ptr) + k) % NUM_REQ;
      if (!any && req[ID_W'(cand)]) begin
        any = 1'b1;
        idx = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/subdomain_rr_scheduler.sv
// Round-robin owner of the shared downstream resource for the leaf
// instances of one sub-domain, with a hold-time limit that revokes a
// grant that overstays.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no owner, arbitrating every cycle
// GRANT   | one requester owns the resource, hold_cnt running
// RELEASE | bus-off cycle after an owner leaves; arbitrates like IDLE
module subdomain_rr_scheduler
  import subdomain_sched_pkg::*;
#(
  parameter int  NUM_REQ  = DEF_NUM_REQ,
  parameter int  MAX_HOLD = 64,
  parameter int  CNT_W    = 16,
  localparam int ID_W     = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout,
  output logic [ID_W-1:0]    timeout_id,
  output logic [CNT_W-1:0]   grant_cnt
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_GRANT   = GRANT;
  localparam logic [1:0] ST_RELEASE = RELEASE;

  // hold_cnt only ever reaches MAX_HOLD-1, so this width is sufficient.
  localparam int HOLD_W = id_w(MAX_HOLD);

  logic [1:0]        state;
  logic [ID_W-1:0]   last_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic              owner_leaves;
  logic              hold_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  // Owner-only release terms; strobes from other requesters never reach here.
  always_comb begin
    owner_leaves = done[gnt_id] || !req[gnt_id];
    hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  end

  assign gnt_valid = |gnt;

  // Arbitration, ownership tracking, hold limit and grant counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      gnt_id     <= '0;
      last_ptr   <= ID_W'(NUM_REQ - 1);
      hold_cnt   <= '0;
      grant_cnt  <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_GRANT: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          // A voluntary release in the limit cycle takes precedence.
          if (owner_leaves) begin
            state    <= ST_RELEASE;
            gnt      <= '0;
            last_ptr <= gnt_id;
          end else if (hold_expired) begin
            state      <= ST_RELEASE;
            gnt        <= '0;
            last_ptr   <= gnt_id;
            timeout    <= 1'b1;
            timeout_id <= gnt_id;
          end
        end
        default: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            gnt      <= NUM_REQ'(1) << pick_idx;
            gnt_id   <= pick_idx;
            hold_cnt <= '0;
            if (grant_cnt != {CNT_W{1'b1}}) begin
              grant_cnt <= grant_cnt + CNT_W'(1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/subdomain_rr_scheduler.md
# subdomain_rr_scheduler

Round-robin scheduler that shares one downstream resource between the five leaf instances of a generated sub-domain. Each leaf raises a request, receives an exclusive grant, and releases it with a done strobe. A hold-time limit forcibly revokes a grant that overstays. The block sits beside the five leaf instances inside their parent sub-domain module, and is the only driver of resource ownership there.

## Interface
- NUM_REQ, 5, number of requesters (2..16)
- MAX_HOLD, 64, maximum GRANT cycles per ownership (2..65535)
- CNT_W, 16, width of the saturating grant counter

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- req  in  NUM_REQ  level request per requester
- done  in  NUM_REQ  one-cycle release strobe per requester
- gnt  out  NUM_REQ  one-hot grant, registered; reset 0
- gnt_valid  out  1  OR of gnt; reset 0
- gnt_id  out  $clog2(NUM_REQ)  index of current/last owner; reset 0
- timeout  out  1  one-cycle pulse on forced revoke; reset 0
- timeout_id  out  $clog2(NUM_REQ)  owner revoked by last timeout; reset 0
- grant_cnt  out  CNT_W  total grants issued, saturates at all-ones; reset 0

## Operation
- FSM states: IDLE, GRANT, RELEASE. Reset state is IDLE, with last_ptr = NUM_REQ-1, so requester 0 has top priority after reset.
- Arbitration (IDLE or RELEASE):
  - Pick the first set req bit scanning from last_ptr+1 upward, wrapping modulo NUM_REQ.
  - If any bit is set: go to GRANT, set gnt[i], gnt_id=i, clear hold_cnt, increment grant_cnt.
  - If no bit is set: go to IDLE (or stay there).
- GRANT:
  - hold_cnt increments every cycle.
  - Release condition: done[gnt_id]=1 OR req[gnt_id]=0. On release go to RELEASE, clear gnt, set last_ptr=gnt_id.
  - Else if hold_cnt==MAX_HOLD-1: go to RELEASE, clear gnt, set last_ptr=gnt_id, pulse timeout, set timeout_id=gnt_id.
  - If done and the limit occur in the same cycle, done wins and no timeout is raised.
- done from non-owners is ignored in all states. done in IDLE is ignored.
- req may drop at any time. A dropped non-owner request is simply not selected.
- gnt_id holds its value through RELEASE and IDLE.
- rst asserted mid-GRANT:
  - All outputs clear immediately (asynchronously).
  - last_ptr returns to NUM_REQ-1.
  - grant_cnt returns to 0.

## Timing
- Request latency: req sampled high in IDLE at cycle N gives gnt high at N+1.
- Release latency: done at cycle N gives gnt low at N+1 (RELEASE). The next grant is visible at N+2 at the earliest.
- Bus-off gap: at least one cycle with gnt=0 between any two owners, including back-to-back re-grant of the same requester.
- Timeout: grant first high at cycle G is revoked with gnt low at G+MAX_HOLD; timeout is high that same cycle.
- grant_cnt updates on the same edge that raises gnt.
- All outputs are registered. There is no combinational path from req or done to any output.

## Structure
- Package subdomain_sched_pkg:
  - sched_state_e enum (IDLE, GRANT, RELEASE)
  - default NUM_REQ localparam
  - ID_W function/localparam = $clog2(NUM_REQ)
- Sub-module rr_pick, purely combinational:
  - inputs: req vector, last_ptr
  - outputs: any, idx
  - rotating priority encoder, reusable by sibling sub-domain schedulers.
- The top module holds the FSM, hold_cnt, last_ptr and grant_cnt registers.

## Test plan
- Reset, then req=5'b10100 held: gnt=5'b00100 at N+1 with gnt_id=2. done[2] at N+3 gives gnt=0 at N+4 and gnt=5'b10000 at N+5.
- All req=5'b11111, each owner pulses done after 2 grant cycles: grant order is 0,1,2,3,4,0; gnt=0 for exactly one cycle between owners; grant_cnt=6.
- MAX_HOLD=8, req[3] held with no done: gnt[3] is high for exactly 8 cycles; timeout=1 and timeout_id=3 in the first cycle gnt=0; re-grant to 3 follows one cycle later.
- Owner 1 granted, done[4] and done[0] pulsed, then req[1] dropped: the stray dones are ignored; gnt clears on the cycle after req[1] falls; timeout stays 0.
- done[gnt_id] in the same cycle hold_cnt==MAX_HOLD-1: normal release with timeout=0. Separately, rst pulsed mid-GRANT: gnt=0 and grant_cnt=0 immediately, and the next grant with req=5'b11111 goes to requester 0.
- CNT_W=4, 20 grants issued: grant_cnt saturates at 15 and arbitration continues unaffected.
